// File: rtl/hold_flag_ctrl.sv
// Pipeline hold/flush scheduler: arbitrates trap > jump > bus-wait > load-use into hold codes plus a PC redirect.
// Latency: inputs sampled at a clock edge, registered response visible right after it; HOLD_PERF_CNT_EN adds perf counters.
// Backpressure: bus_wait_i parks the FSM in STALL; traps are not acked until STALL or an ongoing TRAP ends.
module hold_flag_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int TRAP_CYCLES  = 3
`ifdef HOLD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              trap_ack_o,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              load_use_i,
    input  logic              bus_wait_i,
    output logic [2:0]        hold_flag_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              busy_o
`ifdef HOLD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_TRAP, S_STALL} state_t;

    localparam int MAXC = (TRAP_CYCLES > FLUSH_CYCLES) ? TRAP_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] TRAP_INIT  = CW'(TRAP_CYCLES - 1);

    localparam logic [2:0] HOLD_NONE   = 3'b000;
    localparam logic [2:0] HOLD_JUMP   = 3'b001;
    localparam logic [2:0] HOLD_BUBBLE = 3'b010;
    localparam logic [2:0] HOLD_TRAP   = 3'b100;
    localparam logic [2:0] HOLD_STALL  = 3'b101;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [2:0]          r_hold;
    logic                r_redirect;
    logic [ADDR_W-1:0]   r_redirect_addr;
    logic                r_trap_ack;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_pend_nxt;
    logic [ADDR_W-1:0]   w_pend_addr_nxt;
    logic                w_arb;
    logic                w_take_trap;
    logic                w_take_jump;
    logic                w_load_use;
    logic [ADDR_W-1:0]   w_jump_addr;
    logic [2:0]          w_hold_nxt;
    logic                w_redirect_nxt;
    logic [ADDR_W-1:0]   w_redirect_addr_nxt;
    logic                w_trap_ack_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_pend          <= 1'b0;
            r_pend_addr     <= '0;
            r_hold          <= HOLD_NONE;
            r_redirect      <= 1'b0;
            r_redirect_addr <= '0;
            r_trap_ack      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pend          <= w_pend_nxt;
            r_pend_addr     <= w_pend_addr_nxt;
            r_hold          <= w_hold_nxt;
            r_redirect      <= w_redirect_nxt;
            r_redirect_addr <= w_redirect_addr_nxt;
            r_trap_ack      <= w_trap_ack_nxt;
        end
    end

    // Leaving STALL re-runs the IDLE arbitration in the same cycle, so both share one path.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pend_nxt      = r_pend;
        w_pend_addr_nxt = r_pend_addr;
        w_take_trap     = 1'b0;
        w_take_jump     = 1'b0;
        w_load_use      = 1'b0;
        w_jump_addr     = jump_req_i ? jump_addr_i : r_pend_addr;
        w_arb           = (r_state == S_IDLE) || ((r_state == S_STALL) && !bus_wait_i);
        if (w_arb) begin
            if (trap_req_i) begin
                w_take_trap = 1'b1;
                w_state_nxt = S_TRAP;
                w_cnt_nxt   = TRAP_INIT;
            end else if (jump_req_i || r_pend) begin
                w_take_jump = 1'b1;
                w_state_nxt = S_FLUSH;
                w_cnt_nxt   = FLUSH_INIT;
                w_pend_nxt  = 1'b0;
            end else if (bus_wait_i) begin
                w_state_nxt = S_STALL;
            end else begin
                w_state_nxt = S_IDLE;
                w_load_use  = load_use_i;
            end
        end else begin
            case (r_state)
                S_STALL: begin
                    if (jump_req_i) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = jump_addr_i;
                    end
                end
                S_FLUSH: begin
                    if (trap_req_i) begin
                        w_take_trap = 1'b1;
                        w_state_nxt = S_TRAP;
                        w_cnt_nxt   = TRAP_INIT;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_TRAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_hold_nxt          = HOLD_NONE;
        w_redirect_nxt      = 1'b0;
        w_redirect_addr_nxt = r_redirect_addr;
        w_trap_ack_nxt      = 1'b0;
        if (w_take_trap) begin
            w_hold_nxt          = HOLD_TRAP;
            w_redirect_nxt      = 1'b1;
            w_redirect_addr_nxt = trap_addr_i;
            w_trap_ack_nxt      = 1'b1;
        end else if (w_take_jump) begin
            w_hold_nxt          = HOLD_JUMP;
            w_redirect_nxt      = 1'b1;
            w_redirect_addr_nxt = w_jump_addr;
        end else begin
            case (w_state_nxt)
                S_STALL: w_hold_nxt = HOLD_STALL;
                S_FLUSH: w_hold_nxt = HOLD_JUMP;
                S_TRAP:  w_hold_nxt = HOLD_TRAP;
                default: w_hold_nxt = w_load_use ? HOLD_BUBBLE : HOLD_NONE;
            endcase
        end
    end

    assign hold_flag_o     = r_hold;
    assign redirect_o      = r_redirect;
    assign redirect_addr_o = r_redirect_addr;
    assign trap_ack_o      = r_trap_ack;
    assign busy_o          = (r_state != S_IDLE) || r_pend;

`ifdef HOLD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == S_STALL) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((r_state == S_FLUSH) || (r_state == S_TRAP)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hold_flag_ctrl.sv
// Directed bench for hold_flag_ctrl: a schedule-queue reference model checked every cycle, plus literal checkpoints.
// Traps are requested at level and dropped once the ack is observed, as a real requester would.
module tb_hold_flag_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int TRAP_CYCLES  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_addr_i = '0;
    logic        trap_ack_o;
    logic        jump_req_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        load_use_i = 1'b0;
    logic        bus_wait_i = 1'b0;
    logic [2:0]  hold_flag_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        busy_o;
`ifdef HOLD_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    hold_flag_ctrl #(
        .ADDR_W       (32),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TRAP_CYCLES  (TRAP_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trap_req_i      (trap_req_i),
        .trap_addr_i     (trap_addr_i),
        .trap_ack_o      (trap_ack_o),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .load_use_i      (load_use_i),
        .bus_wait_i      (bus_wait_i),
        .hold_flag_o     (hold_flag_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .busy_o          (busy_o)
`ifdef HOLD_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a window is a queue of hold codes still to be shown; outside a
    // window the controller is either idle or parked on the bus.
    localparam int M_IDLE  = 0;
    localparam int M_WIN   = 1;
    localparam int M_STALL = 2;

    int          m_mode = M_IDLE;
    bit          m_win_trap;
    logic [2:0]  m_sched[$];
    logic [2:0]  m_hold;
    bit          m_redir;
    bit          m_ack;
    logic [31:0] m_addr;
    bit          m_pend;
    logic [31:0] m_paddr;
    int          m_stall_n;
    int          m_flush_n;

    task automatic open_window(input bit is_trap, input int len, input logic [2:0] code, input logic [31:0] addr);
        m_mode     = M_WIN;
        m_win_trap = is_trap;
        m_sched.delete();
        for (int k = 1; k < len; k++) m_sched.push_back(code);
        m_hold  = code;
        m_redir = 1'b1;
        m_addr  = addr;
        m_ack   = is_trap;
    endtask

    task automatic arbitrate();
        if (trap_req_i) begin
            open_window(1'b1, TRAP_CYCLES, 3'b100, trap_addr_i);
        end else if (jump_req_i || m_pend) begin
            open_window(1'b0, FLUSH_CYCLES, 3'b001, jump_req_i ? jump_addr_i : m_paddr);
            m_pend = 1'b0;
        end else if (bus_wait_i) begin
            m_mode = M_STALL;
            m_hold = 3'b101;
        end else begin
            m_mode = M_IDLE;
            m_hold = load_use_i ? 3'b010 : 3'b000;
        end
    endtask

    always @(posedge clk) begin
        m_ack   = 1'b0;
        m_redir = 1'b0;
        if (rst) begin
            m_mode    = M_IDLE;
            m_sched.delete();
            m_hold    = 3'b000;
            m_addr    = '0;
            m_pend    = 1'b0;
            m_paddr   = '0;
            m_stall_n = 0;
            m_flush_n = 0;
        end else begin
            if (m_mode == M_STALL) m_stall_n++;
            if (m_mode == M_WIN)   m_flush_n++;
            if (m_mode == M_WIN) begin
                if (!m_win_trap && trap_req_i) begin
                    open_window(1'b1, TRAP_CYCLES, 3'b100, trap_addr_i);
                end else if (m_sched.size() > 0) begin
                    m_hold = m_sched.pop_front();
                end else begin
                    m_mode = M_IDLE;
                    m_hold = 3'b000;
                end
            end else if (m_mode == M_STALL && bus_wait_i) begin
                m_hold = 3'b101;
                if (jump_req_i) begin
                    m_pend  = 1'b1;
                    m_paddr = jump_addr_i;
                end
            end else begin
                arbitrate();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_hold",  64'(hold_flag_o),     64'(m_hold));
            chk("model_redir", 64'(redirect_o),      64'(m_redir));
            chk("model_addr",  64'(redirect_addr_o), 64'(m_addr));
            chk("model_ack",   64'(trap_ack_o),      64'(m_ack));
            chk("model_busy",  64'(busy_o),          64'((m_mode != M_IDLE) || m_pend));
`ifdef HOLD_PERF_CNT_EN
            chk("model_stall_cnt", 64'(stall_cnt_o), 64'(m_stall_n));
            chk("model_flush_cnt", 64'(flush_cnt_o), 64'(m_flush_n));
`endif
        end
    end

    task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic lu, input logic bw);
        rst         = r;
        jump_req_i  = j;
        jump_addr_i = ja;
        load_use_i  = lu;
        bus_wait_i  = bw;
        @(negedge clk);
        if (r || trap_ack_o) trap_req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string nm, input logic [2:0] hold, input logic redir, input logic ack, input logic busy);
        chk({nm, "_hold"},  64'(hold_flag_o), 64'(hold));
        chk({nm, "_redir"}, 64'(redirect_o),  64'(redir));
        chk({nm, "_ack"},   64'(trap_ack_o),  64'(ack));
        chk({nm, "_busy"},  64'(busy_o),      64'(busy));
    endtask

    initial begin
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        pin("reset", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("reset_addr", 64'(redirect_addr_o), 64'h0);
        idle(1);

        // Jump: two cycles of 001 with a single redirect pulse.
        step(1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
        pin("jump_c0", 3'b001, 1'b1, 1'b0, 1'b1);
        chk("jump_addr", 64'(redirect_addr_o), 64'h8000_0100);
        idle(1);
        pin("jump_c1", 3'b001, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("jump_end", 3'b000, 1'b0, 1'b0, 1'b0);

        // Trap and jump together: trap wins, jump is dropped.
        trap_req_i  = 1'b1;
        trap_addr_i = 32'h8000_0004;
        step(1'b0, 1'b1, 32'h0000_0999, 1'b0, 1'b0);
        pin("trap_c0", 3'b100, 1'b1, 1'b1, 1'b1);
        chk("trap_addr", 64'(redirect_addr_o), 64'h8000_0004);
        idle(1);
        pin("trap_c1", 3'b100, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("trap_c2", 3'b100, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("trap_end", 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1);
        pin("trap_nojump", 3'b000, 1'b0, 1'b0, 1'b0);

        // Bus wait with a jump latched mid-stall, replayed as a flush on release.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        pin("stall_c0", 3'b101, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        pin("stall_c3", 3'b101, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("stall_flush", 3'b001, 1'b1, 1'b0, 1'b1);
        chk("stall_flush_addr", 64'(redirect_addr_o), 64'h200);
        idle(2);
        pin("stall_done", 3'b000, 1'b0, 1'b0, 1'b0);
`ifdef HOLD_PERF_CNT_EN
        chk("perf_stall", 64'(stall_cnt_o), 64'd4);
        chk("perf_flush", 64'(flush_cnt_o), 64'd2);
`endif

        // Load-use bubble lasts one cycle and never raises busy.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pin("lu_c0", 3'b010, 1'b0, 1'b0, 1'b0);
        idle(1);
        pin("lu_end", 3'b000, 1'b0, 1'b0, 1'b0);

        // A jump arriving during FLUSH is ignored.
        step(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
        pin("flush_ign", 3'b001, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("flush_ign_end", 3'b000, 1'b0, 1'b0, 1'b0);

        // Trap during a stall waits for bus release.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        trap_req_i  = 1'b1;
        trap_addr_i = 32'h0000_0700;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        pin("stall_trap_wait", 3'b101, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        pin("stall_trap_take", 3'b100, 1'b1, 1'b1, 1'b1);
        // Second trap raised during TRAP is only accepted after the window closes.
        trap_req_i  = 1'b1;
        trap_addr_i = 32'h0000_0800;
        idle(2);
        pin("trap_wait", 3'b100, 1'b0, 1'b0, 1'b1);
        idle(1);
        pin("trap_gap", 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1);
        pin("trap_second", 3'b100, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Trap preempts FLUSH, then reset lands mid-TRAP.
        step(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        trap_req_i  = 1'b1;
        trap_addr_i = 32'h0000_0400;
        idle(1);
        pin("preempt", 3'b100, 1'b1, 1'b1, 1'b1);
        chk("preempt_addr", 64'(redirect_addr_o), 64'h400);
        idle(1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        pin("rst_mid", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_addr", 64'(redirect_addr_o), 64'h0);
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
